// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the round-robin tri-state bus arbiter.
// Provides the FSM state encoding, default parameter values and counter widths.
package bus_arbiter_pkg;

    // FSM state encoding; the bench decodes these values directly
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } arb_state_e;

    localparam int unsigned DEF_N_REQ       = 4;
    localparam int unsigned DEF_MAX_HOLD    = 4;
    localparam int unsigned DEF_TURN_CYCLES = 1;

    localparam int unsigned HOLD_W = 4;
    localparam int unsigned TURN_W = 2;

endpackage : bus_arbiter_pkg

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
// Ports:
//   req_i    request vector
//   ptr_i    highest-priority index
//   found_c  any request set
//   idx_c    index of the chosen request
//   onehot_c one-hot form of idx_c (zero when nothing found)
module bus_arbiter_rr_pick #(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_c,
    output logic [IDX_W-1:0] idx_c,
    output logic [N_REQ-1:0] onehot_c
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   off;
    logic [IDX_W:0]     sum;

    // Rotate so ptr_i lands at bit 0, priority-encode lowest bit, then unrotate
    always_comb begin
        dbl     = {req_i, req_i} >> ptr_i;
        rot     = dbl[N_REQ-1:0];
        found_c = 1'b0;
        off     = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found_c = 1'b1;
                off     = IDX_W'(i);
            end
        end
        // Modulo add: N_REQ need not be a power of two
        sum = {1'b0, off} + {1'b0, ptr_i};
        if (sum >= (IDX_W+1)'(N_REQ)) begin
            sum = sum - (IDX_W+1)'(N_REQ);
        end
        idx_c    = sum[IDX_W-1:0];
        onehot_c = found_c ? (N_REQ'(1) << idx_c) : '0;
    end

endmodule : bus_arbiter_rr_pick

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for a shared tri-state bus made of per-requester buffer slices.
// Bounded tenure, no preemption, and a dead turnaround gap between owners.
// Ports:
//   clk      rising-edge clock
//   reset    synchronous active-high reset
//   req      level request per requester
//   grant    registered one-hot-or-zero enable, one bit per bus slice
//   owner    index of current grantee, valid while bus_busy
//   bus_busy registered |grant
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter  int unsigned N_REQ       = DEF_N_REQ,
    parameter  int unsigned MAX_HOLD    = DEF_MAX_HOLD,
    parameter  int unsigned TURN_CYCLES = DEF_TURN_CYCLES,
    localparam int unsigned IDX_W       = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] owner,
    output logic             bus_busy
);

    arb_state_e        state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  ptr_q,   ptr_d;
    logic [HOLD_W-1:0] hold_q,  hold_d;
    logic [TURN_W-1:0] turn_q,  turn_d;
    logic              busy_q;
    logic              arb;

    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    logic [N_REQ-1:0]  pick_onehot;

    bus_arbiter_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .found_c  (pick_found),
        .idx_c    (pick_idx),
        .onehot_c (pick_onehot)
    );

    // State, counters and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            turn_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            turn_q  <= turn_d;
            busy_q  <= |grant_d;
        end
    end

    // Next-state logic; IDLE and the last TURN cycle share the arbitration path
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        turn_d  = turn_q;
        arb     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                arb = 1'b1;
            end
            ST_GRANT: begin
                if (req[owner_q] && (hold_q < HOLD_W'(MAX_HOLD))) begin
                    hold_d = hold_q + HOLD_W'(1);
                end else begin
                    grant_d = '0;
                    ptr_d   = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
                    turn_d  = TURN_W'(1);
                    state_d = ST_TURN;
                end
            end
            ST_TURN: begin
                grant_d = '0;
                if (turn_q < TURN_W'(TURN_CYCLES)) begin
                    turn_d = turn_q + TURN_W'(1);
                end else begin
                    arb = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase

        if (arb) begin
            if (pick_found) begin
                grant_d = pick_onehot;
                owner_d = pick_idx;
                hold_d  = HOLD_W'(1);
                state_d = ST_GRANT;
            end else begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        end
    end

    assign grant    = grant_q;
    assign owner    = owner_q;
    assign bus_busy = busy_q;

endmodule : bus_arbiter

// File: tb/tb_bus_arbiter.sv
// Directed and randomised checks of bus_arbiter with N_REQ=4, MAX_HOLD=4, TURN_CYCLES=1.
// The shared bus is modelled as resolved buffer slices: conflicts show up as X.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    localparam int TC = 1;
    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       bus_busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] slice_data [4];
    logic [3:0] bus;
    int         zero_run, hold_run;
    logic       seen;
    logic [3:0] prev_g;
    int         wait_cnt [4];
    logic       chk_wait = 1'b0;

    bus_arbiter #(.N_REQ(4), .MAX_HOLD(4), .TURN_CYCLES(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .grant    (grant),
        .owner    (owner),
        .bus_busy (bus_busy)
    );

    always #5 clk = ~clk;

    // Resolved tri-state bus: more than one enabled slice yields X
    always_comb begin
        logic drv;
        drv = 1'b0;
        bus = 4'bzzzz;
        for (int i = 0; i < 4; i++) begin
            if (grant[i]) begin
                bus = drv ? 4'bxxxx : slice_data[i];
                drv = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then check the per-cycle invariants
    task automatic tick();
        logic       r;
        logic [3:0] rq;
        r  = reset;
        rq = req;
        @(posedge clk);
        #1;
        if (r) begin
            zero_run = 0;
            hold_run = 0;
            seen     = 1'b0;
            for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        end else begin
            chk("onehot0", 32'($onehot0(grant)), 32'd1);
            chk("busy_eq", 32'(bus_busy), 32'(|grant));
            if (bus_busy) begin
                chk("bus_no_x", 32'($isunknown(bus)), 32'd0);
                chk("bus_data", 32'(bus), 32'(slice_data[owner]));
            end
            if (grant != 4'b0000) begin
                if (prev_g == 4'b0000) begin
                    if (seen) chk("turn_gap", 32'(zero_run >= TC), 32'd1);
                    hold_run = 1;
                end else begin
                    chk("owner_stable", 32'(grant), 32'(prev_g));
                    hold_run++;
                    chk("tenure_len", 32'(hold_run <= MH), 32'd1);
                end
                seen     = 1'b1;
                zero_run = 0;
            end else begin
                zero_run++;
            end
            if (chk_wait) begin
                for (int i = 0; i < 4; i++) begin
                    if (rq[i] && !grant[i]) begin
                        wait_cnt[i]++;
                        chk("wait_bound", 32'(wait_cnt[i] <= 20), 32'd1);
                    end else begin
                        wait_cnt[i] = 0;
                    end
                end
            end
        end
        prev_g = grant;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'b0000;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        slice_data[0] = 4'h3;
        slice_data[1] = 4'h5;
        slice_data[2] = 4'hA;
        slice_data[3] = 4'hC;
        prev_g = 4'b0000;

        // Reset state
        tick();
        tick();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_owner", 32'(owner), 32'h0);
        chk("rst_busy", 32'(bus_busy), 32'h0);
        chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        chk("rst_ptr", 32'(dut.ptr_q), 32'h0);
        chk("rst_hold", 32'(dut.hold_q), 32'h0);
        chk("rst_turn", 32'(dut.turn_q), 32'h0);
        reset = 1'b0;

        // 1: reset mid-tenure
        req = 4'b0001;
        tick();
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_busy", 32'(bus_busy), 32'h1);
        reset = 1'b1;
        tick();
        chk("t1_rst_grant", 32'(grant), 32'h0);
        chk("t1_rst_busy", 32'(bus_busy), 32'h0);
        chk("t1_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
        reset = 1'b0;
        tick();
        chk("t1_regrant", 32'(grant), 32'h1);
        do_reset();

        // 2: single long requester, 4 on / 1 off
        req = 4'b0010;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("t2_grant", 32'(grant), (k % 5 < 4) ? 32'h2 : 32'h0);
            chk("t2_busy", 32'(bus_busy), (k % 5 < 4) ? 32'h1 : 32'h0);
        end
        do_reset();

        // 3: round robin across all requesters
        req = 4'b1111;
        for (int k = 0; k < 21; k++) begin
            tick();
            if (k % 5 < 4) begin
                chk("t3_grant", 32'(grant), 32'h1 << ((k / 5) % 4));
                chk("t3_owner", 32'(owner), 32'((k / 5) % 4));
            end else begin
                chk("t3_gap", 32'(grant), 32'h0);
            end
        end
        do_reset();

        // 4: early release
        req = 4'b0100;
        tick();
        chk("t4_grant_a", 32'(grant), 32'h4);
        tick();
        chk("t4_grant_b", 32'(grant), 32'h4);
        req = 4'b0000;
        tick();
        chk("t4_rel_grant", 32'(grant), 32'h0);
        chk("t4_rel_state", 32'(dut.state_q), 32'(ST_TURN));
        tick();
        chk("t4_idle_state", 32'(dut.state_q), 32'(ST_IDLE));
        chk("t4_idle_grant", 32'(grant), 32'h0);
        chk("t4_ptr", 32'(dut.ptr_q), 32'h3);

        // 5: wrap and no preemption
        req = 4'b1000;
        tick();
        chk("t5_grant3", 32'(grant), 32'h8);
        chk("t5_owner3", 32'(owner), 32'h3);
        req = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t5_keep", 32'(grant), 32'h8);
        end
        tick();
        chk("t5_rel_grant", 32'(grant), 32'h0);
        chk("t5_rel_ptr", 32'(dut.ptr_q), 32'h0);
        tick();
        chk("t5_wrap_grant", 32'(grant), 32'h1);
        chk("t5_wrap_owner", 32'(owner), 32'h0);
        do_reset();

        // 6: random contention with sticky requests
        chk_wait = 1'b1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
            end
            slice_data[2'($urandom_range(0, 3))] = 4'($urandom);
            tick();
        end
        chk_wait = 1'b0;
        req = 4'b0000;
        repeat (8) tick();
        chk("t6_drain", 32'(grant), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_bus_arbiter
